// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
// Instruction fetch front end. Holds the fetch PC, issues sequential requests
// to the instruction cache over a busywait handshake, and buffers returned
// instructions with their PCs in a DEPTH-entry queue that decode drains via
// a valid/ready handshake. A redirect flushes the queue and restarts fetch;
// if it arrives while a cache miss is outstanding, the unit parks in DRAIN
// until the old request completes and its data can be thrown away.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   imem_addr/read      cache request address and request valid
//   imem_rdata          cache read data (valid when read=1 and busywait=0)
//   imem_busywait       cache busy; request is held while high
//   redirect_valid/addr taken branch/jump and its target
//   instr_valid/instr   queue head valid flag and instruction (0 if empty)
//   instr_pc/pc_next    head PC and head PC + PC_STEP (0 if empty)
//   instr_ready         decode accepts the head this cycle
//   queue_count         number of occupied queue entries

module fetch_queue_unit #(
  parameter int              XLEN         = 32,
  parameter int              DEPTH        = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              PC_STEP      = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic [XLEN-1:0]            imem_addr,
  output logic                       imem_read,
  input  logic [XLEN-1:0]            imem_rdata,
  input  logic                       imem_busywait,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_addr,
  output logic                       instr_valid,
  output logic [XLEN-1:0]            instr,
  output logic [XLEN-1:0]            instr_pc,
  output logic [XLEN-1:0]            instr_pc_next,
  input  logic                       instr_ready,
  output logic [$clog2(DEPTH):0]     queue_count
);

  localparam int              PTR_W      = $clog2(DEPTH);
  localparam int              CNT_W      = PTR_W + 1;
  localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(STEP - XLEN'(1));

  typedef enum logic {
    RUN,
    DRAIN
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [XLEN-1:0]       fetch_pc;
  logic [XLEN-1:0]       held_pc;
  logic [XLEN-1:0]       instr_mem [DEPTH];
  logic [XLEN-1:0]       pc_mem    [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [XLEN-1:0]       target;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  miss_redirect;

  // Request side. The read strobe is forced low while reset is asserted so the
  // cache sees the request drop immediately. In DRAIN the stale miss address
  // must be held stable until the cache finishes with it.
  always_comb begin
    full      = (count == CNT_W'(DEPTH));
    target    = redirect_addr & ALIGN_MASK;
    imem_addr = fetch_pc;
    imem_read = 1'b0;
    if (!reset) begin
      if (state == DRAIN) begin
        imem_addr = held_pc;
        imem_read = 1'b1;
      end else begin
        imem_read = !full;
      end
    end
    // A redirect on the same edge wins over any returning data or pop.
    push          = (state == RUN) && imem_read && !imem_busywait && !redirect_valid;
    pop           = instr_valid && instr_ready && !redirect_valid;
    miss_redirect = (state == RUN) && redirect_valid && imem_read && imem_busywait;
  end

  // Next-state logic. DRAIN is left as soon as the outstanding miss completes;
  // any redirect arriving meanwhile only updates fetch_pc.
  always_comb begin
    next_state = state;
    case (state)
      RUN:     if (miss_redirect) next_state = DRAIN;
      DRAIN:   if (!imem_busywait) next_state = RUN;
      default: next_state = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= next_state;
  end

  // Fetch PC tracking. On a redirect during a miss the in-flight address is
  // remembered in held_pc so the cache request stays unchanged; the latest
  // redirect target always lands in fetch_pc.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_VECTOR;
      held_pc  <= RESET_VECTOR;
    end else if (redirect_valid) begin
      fetch_pc <= target;
      if (miss_redirect) held_pc <= fetch_pc;
    end else if (push) begin
      fetch_pc <= fetch_pc + STEP;
    end
  end

  // Queue pointers and occupancy. A redirect flushes everything; otherwise a
  // simultaneous push and pop leaves the count unchanged. Pointers wrap
  // naturally since DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage; contents are only meaningful under the count, so no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      instr_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]    <= fetch_pc;
    end
  end

  // Head presentation, zeroed when the queue is empty.
  always_comb begin
    instr_valid   = (count != '0);
    instr         = '0;
    instr_pc      = '0;
    instr_pc_next = '0;
    if (instr_valid) begin
      instr         = instr_mem[rd_ptr];
      instr_pc      = pc_mem[rd_ptr];
      instr_pc_next = pc_mem[rd_ptr] + STEP;
    end
    queue_count = count;
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit
// Directed self-checking bench for fetch_queue_unit. A main instance with
// RESET_VECTOR=0 is driven by hand-built vectors; a second instance with
// RESET_VECTOR=0xFFFFFFF8 free-runs with an always-hitting cache to show PC
// wrap-around. The cache model returns address ^ DATA_KEY.

module tb_fetch_queue_unit;

  localparam logic [31:0] DATA_KEY = 32'h5A5A_0000;

  logic        clock;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_read;
  logic [31:0] imem_rdata;
  logic        imem_busywait;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_next;
  logic        instr_ready;
  logic [2:0]  queue_count;

  logic [31:0] w_addr;
  logic        w_read;
  logic [31:0] w_rdata;
  logic        w_busywait;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_addr;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [31:0] w_pc_next;
  logic        w_ready;
  logic [2:0]  w_count;

  int tests_run    = 0;
  int tests_failed = 0;

  fetch_queue_unit #(
    .XLEN(32), .DEPTH(4), .RESET_VECTOR(32'h0000_0000), .PC_STEP(4)
  ) u_dut (
    .clock(clock), .reset(reset),
    .imem_addr(imem_addr), .imem_read(imem_read), .imem_rdata(imem_rdata),
    .imem_busywait(imem_busywait),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_pc_next(instr_pc_next), .instr_ready(instr_ready),
    .queue_count(queue_count)
  );

  fetch_queue_unit #(
    .XLEN(32), .DEPTH(4), .RESET_VECTOR(32'hFFFF_FFF8), .PC_STEP(4)
  ) u_wrap (
    .clock(clock), .reset(reset),
    .imem_addr(w_addr), .imem_read(w_read), .imem_rdata(w_rdata),
    .imem_busywait(w_busywait),
    .redirect_valid(w_redirect_valid), .redirect_addr(w_redirect_addr),
    .instr_valid(w_valid), .instr(w_instr), .instr_pc(w_pc),
    .instr_pc_next(w_pc_next), .instr_ready(w_ready),
    .queue_count(w_count)
  );

  assign imem_rdata = imem_addr ^ DATA_KEY;
  assign w_rdata    = w_addr ^ DATA_KEY;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drive inputs away from the edge, clock once, then settle at the negedge.
  task automatic applyStimulus(input logic rv, input logic [31:0] ra,
                               input logic bw, input logic rdy);
    redirect_valid = rv;
    redirect_addr  = ra;
    imem_busywait  = bw;
    instr_ready    = rdy;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic doReset(input logic rdy);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    imem_busywait  = 1'b0;
    instr_ready    = rdy;
    @(negedge clock);
    @(negedge clock);
    checkOutput("rst_read",  {31'b0, imem_read},   32'd0);
    checkOutput("rst_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("rst_count", {29'b0, queue_count}, 32'd0);
    checkOutput("rst_instr", instr,                32'd0);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset            = 1'b1;
    w_busywait       = 1'b0;
    w_redirect_valid = 1'b0;
    w_redirect_addr  = '0;
    w_ready          = 1'b1;

    // Sequential fetch with a hitting cache and decode always ready.
    doReset(1'b1);
    checkOutput("seq_read0", {31'b0, imem_read}, 32'd1);
    checkOutput("seq_addr0", imem_addr, 32'h0);
    checkOutput("seq_wrap_addr0", w_addr, 32'hFFFF_FFF8);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("seq_valid1", {31'b0, instr_valid}, 32'd1);
    checkOutput("seq_pc1", instr_pc, 32'h0);
    checkOutput("seq_pcn1", instr_pc_next, 32'h4);
    checkOutput("seq_instr1", instr, 32'h5A5A_0000);
    checkOutput("seq_addr1", imem_addr, 32'h4);
    checkOutput("wrap_pc0", w_pc, 32'hFFFF_FFF8);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      checkOutput("seq_addr", imem_addr, 32'(4 * (i + 1)));
      checkOutput("seq_pc", instr_pc, 32'(4 * i));
      checkOutput("seq_count", {29'b0, queue_count}, 32'd1);
      if (i == 1) begin
        checkOutput("wrap_pc1", w_pc, 32'hFFFF_FFFC);
        checkOutput("wrap_pcn1", w_pc_next, 32'h0);
      end
      if (i == 2) checkOutput("wrap_pc2", w_pc, 32'h0);
    end

    // Decode stalled: queue fills, request drops, then drains in order.
    doReset(1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("full_count", {29'b0, queue_count}, 32'd4);
    checkOutput("full_read", {31'b0, imem_read}, 32'd0);
    checkOutput("full_addr", imem_addr, 32'h10);
    checkOutput("full_head", instr_pc, 32'h0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("full_hold_addr", imem_addr, 32'h10);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      checkOutput("drain_head", instr_pc, 32'(4 * i));
      checkOutput("drain_instr", instr, 32'(4 * i) ^ DATA_KEY);
      checkOutput("drain_count", {29'b0, queue_count}, 32'd3);
    end

    // Redirect in steady state with a misaligned target.
    doReset(1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h103, 1'b0, 1'b1);
    checkOutput("redir_count", {29'b0, queue_count}, 32'd0);
    checkOutput("redir_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("redir_addr", imem_addr, 32'h100);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("redir_pc", instr_pc, 32'h100);
    checkOutput("redir_instr", instr, 32'h100 ^ DATA_KEY);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("redir_pc2", instr_pc, 32'h104);

    // Miss at address 8 with two redirects landing while it is in flight.
    doReset(1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("miss_addr_pre", imem_addr, 32'h8);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    checkOutput("miss_addr1", imem_addr, 32'h8);
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b1);
    checkOutput("miss_addr2", imem_addr, 32'h8);
    checkOutput("miss_read2", {31'b0, imem_read}, 32'd1);
    checkOutput("miss_count2", {29'b0, queue_count}, 32'd0);
    applyStimulus(1'b1, 32'h80, 1'b1, 1'b1);
    checkOutput("miss_addr3", imem_addr, 32'h8);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    checkOutput("miss_addr5", imem_addr, 32'h8);
    checkOutput("miss_valid5", {31'b0, instr_valid}, 32'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("miss_done_addr", imem_addr, 32'h80);
    checkOutput("miss_done_count", {29'b0, queue_count}, 32'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("miss_new_pc", instr_pc, 32'h80);
    checkOutput("miss_new_count", {29'b0, queue_count}, 32'd1);

    // Reset asserted during a miss with two entries queued.
    doReset(1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("rmiss_count", {29'b0, queue_count}, 32'd2);
    checkOutput("rmiss_addr", imem_addr, 32'h8);
    reset = 1'b1;
    #1;
    checkOutput("rmiss_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("rmiss_cnt0", {29'b0, queue_count}, 32'd0);
    checkOutput("rmiss_read", {31'b0, imem_read}, 32'd0);
    @(negedge clock);
    imem_busywait = 1'b0;
    reset = 1'b0;
    #1;
    checkOutput("rmiss_restart_addr", imem_addr, 32'h0);
    checkOutput("rmiss_restart_read", {31'b0, imem_read}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
